tolower_stream: RTL and testbench



---
 rtl/tolower_stream.sv | 101 ++++++++++
 tb/tb_tolower_stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tolower_stream.sv
// Streaming ASCII lowercase converter with a 2-entry output skid FIFO
// and saturating byte / conversion / frame statistics counters.
module tolower_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             convert_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] byte_count,
    output logic [CNT_W-1:0] conv_count,
    output logic [CNT_W-1:0] frame_count,
    output logic [1:0]       dbg_state
);

    // Handshake: a byte moves on a rising edge when valid and ready are both
    // high; the sender holds data/last stable while valid=1 and ready=0.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            r_state;
    logic [8:0]        r_mem [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [CNT_W-1:0]  r_byte_count;
    logic [CNT_W-1:0]  r_conv_count;
    logic [CNT_W-1:0]  r_frame_count;

    logic              w_push;
    logic              w_pop;
    logic              w_is_upper;
    logic              w_conv;
    logic [7:0]        w_byte;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready    = (r_state != FULL);
    assign out_valid   = (r_state != EMPTY);
    assign out_data    = r_mem[r_rd_ptr][7:0];
    assign out_last    = r_mem[r_rd_ptr][8];
    assign byte_count  = r_byte_count;
    assign conv_count  = r_conv_count;
    assign frame_count = r_frame_count;
    assign dbg_state   = r_state;

    assign w_push     = in_valid & in_ready;
    assign w_pop      = out_valid & out_ready;
    assign w_is_upper = (in_data >= 8'h41) && (in_data <= 8'h5A);
    assign w_conv     = convert_en & w_is_upper;
    assign w_byte     = w_conv ? (in_data | 8'h20) : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= EMPTY;
            r_mem[0]      <= '0;
            r_mem[1]      <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_byte_count  <= '0;
            r_conv_count  <= '0;
            r_frame_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {in_last, w_byte};
                r_wr_ptr        <= ~r_wr_ptr;
                if (r_byte_count != CNT_MAX)
                    r_byte_count <= r_byte_count + 1'b1;
                if (w_conv && (r_conv_count != CNT_MAX))
                    r_conv_count <= r_conv_count + 1'b1;
                if (in_last && (r_frame_count != CNT_MAX))
                    r_frame_count <= r_frame_count + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case (r_state)
                EMPTY: if (w_push) r_state <= ONE;
                ONE: begin
                    if (w_push && !w_pop)
                        r_state <= FULL;
                    else if (w_pop && !w_push)
                        r_state <= EMPTY;
                end
                FULL:    if (w_pop) r_state <= ONE;
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_tolower_stream.sv
// Bench for tolower_stream: queue-based reference model checked every cycle,
// plus directed vectors with literal expected output sequences and counters.
module tb_tolower_stream;

    localparam int CNT_W = 4;
    localparam int CNT_MAX_I = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             convert_en;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;
    logic [CNT_W-1:0] byte_count;
    logic [CNT_W-1:0] conv_count;
    logic [CNT_W-1:0] frame_count;
    logic [1:0]       dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] m_q[$];
    logic [8:0] out_log[$];
    int  m_byte = 0;
    int  m_conv = 0;
    int  m_frame = 0;
    bit  m_valid = 0;
    bit  m_after_rst = 0;

    tolower_stream #(.CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .convert_en(convert_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .byte_count(byte_count),
        .conv_count(conv_count), .frame_count(frame_count),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_lower(input logic [7:0] d, input logic ce);
        if (ce && d >= 8'd65 && d <= 8'd90) return d + 8'd32;
        return d;
    endfunction

    // Reference model: compare at the falling edge, then advance the model
    // with the transfers that the coming rising edge will perform.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
            chk("state", 32'(dbg_state), 32'(m_q.size()));
            chk("byte_count", 32'(byte_count), 32'(m_byte));
            chk("conv_count", 32'(conv_count), 32'(m_conv));
            chk("frame_count", 32'(frame_count), 32'(m_frame));
            if (m_q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(m_q[0][7:0]));
                chk("out_last", 32'(out_last), 32'(m_q[0][8]));
            end else if (m_after_rst) begin
                chk("out_data_rst", 32'(out_data), 32'h0);
                chk("out_last_rst", 32'(out_last), 32'h0);
            end
        end
        if (rst) begin
            m_q.delete();
            m_byte = 0; m_conv = 0; m_frame = 0;
            m_valid = 1; m_after_rst = 1;
        end else if (m_valid) begin
            if (out_valid && out_ready) begin
                out_log.push_back({out_last, out_data});
                if (m_q.size() != 0) void'(m_q.pop_front());
            end
            if (in_valid && in_ready) begin
                m_after_rst = 0;
                m_q.push_back({in_last, model_lower(in_data, convert_en)});
                if (m_byte < CNT_MAX_I) m_byte++;
                if (model_lower(in_data, convert_en) != in_data && m_conv < CNT_MAX_I) m_conv++;
                if (in_last && m_frame < CNT_MAX_I) m_frame++;
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic ce);
        in_valid = 1'b1; in_data = d; in_last = l; convert_en = ce;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!out_valid) begin
                @(posedge clk); #1;
                return;
            end
        end
        chk("drain_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_log(input string name, input logic [8:0] exp[$]);
        chk({name, "_len"}, 32'(out_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_log.size(); i++)
            chk(name, 32'(out_log[i]), 32'(exp[i]));
        out_log.delete();
    endtask

    initial begin
        rst = 1'b1; convert_en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_byte_count", 32'(byte_count), 32'd0);
        @(posedge clk); #1;

        // "Hi!"
        out_ready = 1'b1;
        send(8'h48, 1'b0, 1'b1);
        send(8'h69, 1'b0, 1'b1);
        send(8'h21, 1'b0, 1'b1);
        drain();
        check_log("hi", '{9'h068, 9'h069, 9'h021});
        chk("hi_byte_count", 32'(byte_count), 32'd3);
        chk("hi_conv_count", 32'(conv_count), 32'd1);

        // Range boundaries and bit 7
        do_reset();
        send(8'h40, 1'b0, 1'b1);
        send(8'h41, 1'b0, 1'b1);
        send(8'h5A, 1'b0, 1'b1);
        send(8'h5B, 1'b0, 1'b1);
        send(8'hC1, 1'b0, 1'b1);
        drain();
        check_log("bound", '{9'h040, 9'h061, 9'h07A, 9'h05B, 9'h0C1});
        chk("bound_conv_count", 32'(conv_count), 32'd2);

        // Backpressure: two accepted, third held until out_ready rises
        do_reset();
        out_ready = 1'b0;
        fork
            begin
                send(8'h31, 1'b0, 1'b1);
                send(8'h32, 1'b0, 1'b1);
                send(8'h33, 1'b0, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_state_full", 32'(dbg_state), 32'd2);
                chk("bp_byte_count", 32'(byte_count), 32'd2);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check_log("bp", '{9'h031, 9'h032, 9'h033});

        // Steady push+pop in ONE, frame end on the last byte
        do_reset();
        for (int i = 0; i < 10; i++)
            send(8'h41 + 8'(i), (i == 9), 1'b1);
        drain();
        check_log("one", '{9'h061, 9'h062, 9'h063, 9'h064, 9'h065,
                           9'h066, 9'h067, 9'h068, 9'h069, 9'h16A});
        chk("one_frame_count", 32'(frame_count), 32'd1);
        chk("one_conv_count", 32'(conv_count), 32'd10);

        // Pass-through, then enable toggled while a byte is buffered
        do_reset();
        send(8'h41, 1'b0, 1'b0);
        send(8'h42, 1'b0, 1'b0);
        send(8'h43, 1'b0, 1'b0);
        drain();
        check_log("pass", '{9'h041, 9'h042, 9'h043});
        chk("pass_conv_count", 32'(conv_count), 32'd0);
        out_ready = 1'b0;
        send(8'h41, 1'b0, 1'b0);
        send(8'h41, 1'b0, 1'b1);
        out_ready = 1'b1;
        drain();
        check_log("toggle", '{9'h041, 9'h061});
        chk("toggle_conv_count", 32'(conv_count), 32'd1);

        // Saturation at 4 bits, then reset while FULL
        do_reset();
        for (int i = 0; i < 20; i++)
            send(8'h41 + 8'(i % 26), 1'b0, 1'b1);
        drain();
        chk("sat_byte_count", 32'(byte_count), 32'd15);
        chk("sat_conv_count", 32'(conv_count), 32'd15);
        out_log.delete();
        out_ready = 1'b0;
        send(8'h5A, 1'b1, 1'b1);
        send(8'h5A, 1'b1, 1'b1);
        do_reset();
        @(negedge clk);
        chk("rst_full_out_valid", 32'(out_valid), 32'd0);
        chk("rst_full_in_ready", 32'(in_ready), 32'd1);
        chk("rst_full_byte_count", 32'(byte_count), 32'd0);
        chk("rst_full_frame_count", 32'(frame_count), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_full_no_stale", 32'(out_log.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
